divider_n_seq: RTL and testbench

- Sequential unsigned restoring divider, nb_bit wide.
- Sits directly downstream of subtractor_n: instantiates it once and consumes its diff_o and borrow_o every iteration to build quotient and remainder one bit per clock.
- Used wherever the datapath needs integer division without a combinational array divider.

---
 rtl/divider_pkg.sv | 18 +
 rtl/subtractor_n.sv | 16 +
 rtl/divider_n_seq.sv | 162 ++++++++++++++++
 tb/tb_divider_n_seq.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encoding, the default operand width and the iteration-counter sizing helper.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_NB_BIT_DEFAULT = 8;

    // The counter must hold the values 0..nb_bit.
    function automatic int cnt_width(input int nb_bit);
        return $clog2(nb_bit + 1);
    endfunction

endpackage

// File: rtl/subtractor_n.sv
// Parametric unsigned subtractor. diff_o = a_i - b_i (mod 2**width).
// borrow_o is the carry out of a_i + ~b_i + 1, so it is 1 exactly when
// a_i >= b_i (no borrow needed); the divider uses it as its compare result.
module subtractor_n #(
    parameter int width = 8
) (
    input  logic [width-1:0] a_i,
    input  logic [width-1:0] b_i,
    output logic [width-1:0] diff_o,
    output logic             borrow_o
);

    // Two's-complement subtraction with the carry out exposed.
    assign {borrow_o, diff_o} = {1'b0, a_i} + {1'b0, ~b_i} + (width + 1)'(1);

endmodule

// File: rtl/divider_n_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional feature macro: DIVIDER_EARLY_EXIT_EN -- when defined, a request
// whose dividend is smaller than its (nonzero) divisor skips the iterations.
// Outputs (done_o, busy_o, results) are registered one cycle behind the FSM,
// so a result is presented nb_bit+1 cycles after the start edge (1 cycle for
// divide-by-zero / early exit).
module divider_n_seq
    import divider_pkg::*;
#(
    parameter int nb_bit = DIV_NB_BIT_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [nb_bit-1:0] dividend_i,
    input  logic [nb_bit-1:0] divisor_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [nb_bit-1:0] quotient_o,
    output logic [nb_bit-1:0] remainder_o,
    output logic              div_by_zero_o
);

    localparam int                CNT_W    = cnt_width(nb_bit);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(nb_bit - 1);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_CALC = CALC;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [nb_bit-1:0] dvd_q;     // shifting dividend, MSB feeds the remainder
    logic [nb_bit-1:0] dsr_q;     // latched divisor
    logic [nb_bit-1:0] rem_q;     // partial remainder r
    logic [nb_bit-1:0] quo_q;     // quotient being assembled
    logic              dbz_q;

    logic [nb_bit:0]   sub_a;
    logic [nb_bit:0]   sub_b;
    logic [nb_bit:0]   sub_diff;
    logic              sub_ge;
    logic [nb_bit-1:0] rem_next;
    logic              sub_msb_unused;

    logic accept;
    logic zero_div;
    logic early_exit;

    // A request is taken only in IDLE and only once the previous result's
    // busy window has closed, so a start held through the done cycle waits.
    assign accept   = (state == ST_IDLE) && start_i && !busy_o;
    assign zero_div = (divisor_i == '0);

`ifdef DIVIDER_EARLY_EXIT_EN
    assign early_exit = (dividend_i < divisor_i);
`else
    assign early_exit = 1'b0;
`endif

    // One restoring step: shift the next dividend bit into r and try divisor.
    assign sub_a = {rem_q, dvd_q[nb_bit-1]};
    assign sub_b = {1'b0, dsr_q};

    subtractor_n #(
        .width (nb_bit + 1)
    ) u_sub (
        .a_i      (sub_a),
        .b_i      (sub_b),
        .diff_o   (sub_diff),
        .borrow_o (sub_ge)
    );

    // When a >= b the difference is below the divisor, so its top bit is
    // always zero and only the low nb_bit bits are kept.
    assign sub_msb_unused = sub_diff[nb_bit];
    assign rem_next       = sub_ge ? sub_diff[nb_bit-1:0] : sub_a[nb_bit-1:0];

    // FSM and datapath: load on accept, iterate nb_bit times, then DONE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            cnt   <= '0;
            dvd_q <= '0;
            dsr_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // right-hand side sees the pre-edge values, like real flops.
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (zero_div) begin
                            state <= ST_DONE;
                            quo_q <= '1;
                            rem_q <= dividend_i;
                            dbz_q <= 1'b1;
                        end else if (early_exit) begin
                            state <= ST_DONE;
                            quo_q <= '0;
                            rem_q <= dividend_i;
                            dbz_q <= 1'b0;
                        end else begin
                            state <= ST_CALC;
                            dvd_q <= dividend_i;
                            dsr_q <= divisor_i;
                            rem_q <= '0;
                            quo_q <= '0;
                            cnt   <= '0;
                            dbz_q <= 1'b0;
                        end
                    end
                end
                ST_CALC: begin
                    rem_q <= rem_next;
                    quo_q <= {quo_q[nb_bit-2:0], sub_ge};
                    dvd_q <= {dvd_q[nb_bit-2:0], 1'b0};
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output registers: clear on accept, publish the result while in DONE,
    // drop busy once the done pulse has been seen.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            quotient_o    <= '0;
            remainder_o   <= '0;
            div_by_zero_o <= 1'b0;
        end else begin
            done_o <= (state == ST_DONE);
            if (accept) begin
                busy_o        <= 1'b1;
                quotient_o    <= '0;
                remainder_o   <= '0;
                div_by_zero_o <= 1'b0;
            end else if (state == ST_DONE) begin
                quotient_o    <= quo_q;
                remainder_o   <= rem_q;
                div_by_zero_o <= dbz_q;
            end
            if (done_o) begin
                busy_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_divider_n_seq.sv
// Directed self-checking bench for divider_n_seq (nb_bit = 8).
// Honors DIVIDER_EARLY_EXIT_EN when the same macro is given to the build.
module tb_divider_n_seq;

    localparam int NB = 8;
`ifdef DIVIDER_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [NB-1:0] dividend_i = '0;
    logic [NB-1:0] divisor_i = '0;
    logic          busy_o;
    logic          done_o;
    logic [NB-1:0] quotient_o;
    logic [NB-1:0] remainder_o;
    logic          div_by_zero_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] sweep_a [0:9] = '{8'd0, 8'd1, 8'd2, 8'd7, 8'd100, 8'd127, 8'd128, 8'd200, 8'd254, 8'd255};
    logic [7:0] sweep_b [0:9] = '{8'd1, 8'd2, 8'd3, 8'd7, 8'd16, 8'd127, 8'd128, 8'd200, 8'd254, 8'd255};

    always #5 clk_i = ~clk_i;

    divider_n_seq #(.nb_bit(NB)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .dividend_i    (dividend_i),
        .divisor_i     (divisor_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .quotient_o    (quotient_o),
        .remainder_o   (remainder_o),
        .div_by_zero_o (div_by_zero_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected latency from start edge to the done_o cycle.
    function automatic int exp_latency(input logic [7:0] a, input logic [7:0] b);
        if (b == 8'd0)           return 1;
        if (EARLY && (a < b))    return 1;
        return NB + 1;
    endfunction

    // Issue one request and check latency, busy window, clearing and results.
    task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] eq, input logic [7:0] er, input logic edbz);
        int lat;
        bit busy_ok;
        @(negedge clk_i);
        start_i    = 1'b1;
        dividend_i = a;
        divisor_i  = b;
        @(negedge clk_i);
        start_i = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        check({tag, "/clear"}, {quotient_o, remainder_o, div_by_zero_o}, 64'd0);
        while (!done_o && lat < 40) begin
            if (!busy_o) busy_ok = 1'b0;
            @(negedge clk_i);
            lat++;
        end
        check({tag, "/lat"}, 64'(lat), 64'(exp_latency(a, b)));
        check({tag, "/quo"}, quotient_o, eq);
        check({tag, "/rem"}, remainder_o, er);
        check({tag, "/dbz"}, div_by_zero_o, edbz);
        check({tag, "/busy_win"}, {busy_ok, busy_o}, 2'b11);
        @(negedge clk_i);
        check({tag, "/after"}, {busy_o, done_o, quotient_o, remainder_o}, {2'b00, eq, er});
    endtask

    initial begin
        int lat;
        int dones;
        logic [7:0] a;
        logic [7:0] b;

        // Reset state
        @(negedge clk_i);
        check("reset", {busy_o, done_o, quotient_o, remainder_o, div_by_zero_o}, 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("idle", {busy_o, done_o}, 2'b00);

        // Directed cases
        run_div("200/7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
        run_div("255/1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
        run_div("0/13", 8'd0, 8'd13, 8'd0, 8'd0, 1'b0);
        run_div("5/0", 8'd5, 8'd0, 8'hFF, 8'd5, 1'b1);
        run_div("3/10", 8'd3, 8'd10, 8'd0, 8'd3, 1'b0);
        run_div("0/0", 8'd0, 8'd0, 8'hFF, 8'd0, 1'b1);
        run_div("255/255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0);

        // Second start while busy is ignored
        @(negedge clk_i);
        start_i = 1'b1; dividend_i = 8'd100; divisor_i = 8'd3;
        @(negedge clk_i);
        start_i = 1'b0;
        lat = 0;
        while (!done_o && lat < 40) begin
            start_i = (lat == 3);
            if (lat == 3) begin
                dividend_i = 8'd50;
                divisor_i  = 8'd5;
            end
            @(negedge clk_i);
            lat++;
        end
        start_i = 1'b0;
        check("ign/lat", 64'(lat), 64'(NB + 1));
        check("ign/quo", quotient_o, 8'd33);
        check("ign/rem", remainder_o, 8'd1);
        @(negedge clk_i);
        check("ign/busy_after", busy_o, 1'b0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            if (done_o) dones++;
        end
        check("ign/no_second", 64'(dones), 64'd0);

        // Reset in the middle of an operation
        @(negedge clk_i);
        start_i = 1'b1; dividend_i = 8'd100; divisor_i = 8'd3;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk_i);
        check("rst/busy_before", busy_o, 1'b1);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("rst/outputs", {busy_o, done_o, quotient_o, remainder_o, div_by_zero_o}, 64'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk_i);
            if (done_o || busy_o) dones++;
        end
        check("rst/no_done", 64'(dones), 64'd0);
        run_div("9/2", 8'd9, 8'd2, 8'd4, 8'd1, 1'b0);

        // Sweep of boundary-heavy operand pairs against the integer model
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 10; j++) begin
                a = sweep_a[i];
                b = sweep_b[j];
                run_div("sweep", a, b, a / b, a % b, 1'b0);
                check("sweep/inv", 64'(16'(quotient_o) * 16'(b) + 16'(remainder_o)), 64'(a));
                check("sweep/rem_lt", 64'(remainder_o < b), 64'd1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
